// File: rtl/pipe_stage_rv.sv
// Valid/allow_in pipeline stage register with optional skid entry, synchronous
// flush and a saturating stall-cycle counter.
module pipe_stage_rv #(
  parameter int WIDTH = 64,
  parameter int SKID  = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_allow_in,
  input  logic             ready_go,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_allow_in,
  output logic             stage_valid,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             m_valid_q, m_valid_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_fire, in_fire;

  assign out_valid   = m_valid_q & ready_go;
  assign out_data    = m_data_q;
  assign stage_valid = m_valid_q;
  assign stall_cnt   = cnt_q;
  assign out_fire    = out_valid & out_allow_in;
  assign in_fire     = in_valid & in_allow_in;

  generate
    if (SKID == 0) begin : g_noskid
      assign in_allow_in = !m_valid_q | (ready_go & out_allow_in);

      always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        if (in_allow_in) begin
          m_valid_d = in_valid;
          if (in_valid) m_data_d = in_data;
        end
        if (flush) m_valid_d = 1'b0;
      end
    end else begin : g_skid
      logic             s_valid_q, s_valid_d;
      logic [WIDTH-1:0] s_data_q, s_data_d;

      // Registered allow_in: upstream sees only the skid occupancy.
      assign in_allow_in = !s_valid_q;

      always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        if (flush) begin
          m_valid_d = 1'b0;
          s_valid_d = 1'b0;
        end else if (s_valid_q) begin
          // in_fire is impossible here; the skid drains before new input lands in main.
          if (out_fire) begin
            m_data_d  = s_data_q;
            s_valid_d = 1'b0;
          end
        end else begin
          if (out_fire) m_valid_d = 1'b0;
          if (in_fire) begin
            if (!m_valid_q || out_fire) begin
              m_valid_d = 1'b1;
              m_data_d  = in_data;
            end else begin
              s_valid_d = 1'b1;
              s_data_d  = in_data;
            end
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) s_valid_q <= 1'b0;
        else       s_valid_q <= s_valid_d;
        s_data_q <= s_data_d;
      end
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q;
    if (m_valid_q && !out_fire && !flush && cnt_q != {CNT_W{1'b1}})
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      cnt_q     <= cnt_d;
    end
    m_data_q <= m_data_d;
  end

endmodule

// File: tb/tb_pipe_stage_rv.sv
// Bench for pipe_stage_rv: three shared-stimulus instances (no skid, skid, 2-bit counter)
// checked against a FIFO-occupancy reference model, a vector table and directed sequences.
module tb_pipe_stage_rv;

  logic clk = 1'b0;
  logic reset, flush, in_valid, ready_go, out_allow_in;
  logic [15:0] in_data;

  logic [2:0]       allow, ov, sv;
  logic [2:0][15:0] od;
  logic [7:0]       cnt0, cnt1;
  logic [1:0]       cnt2;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: each stage is a FIFO of depth 1 (no skid) or 2 (skid)
  int          msz [3];
  logic [15:0] mbuf[3][2];
  int          mcnt[3];
  logic [15:0] log1[$];

  always #5 clk = ~clk;

  pipe_stage_rv #(.WIDTH(16), .SKID(0), .CNT_W(8)) u_d0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_allow_in(allow[0]), .ready_go(ready_go), .out_valid(ov[0]), .out_data(od[0]),
    .out_allow_in(out_allow_in), .stage_valid(sv[0]), .stall_cnt(cnt0));

  pipe_stage_rv #(.WIDTH(16), .SKID(1), .CNT_W(8)) u_d1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_allow_in(allow[1]), .ready_go(ready_go), .out_valid(ov[1]), .out_data(od[1]),
    .out_allow_in(out_allow_in), .stage_valid(sv[1]), .stall_cnt(cnt1));

  pipe_stage_rv #(.WIDTH(16), .SKID(0), .CNT_W(2)) u_d2 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_allow_in(allow[2]), .ready_go(ready_go), .out_valid(ov[2]), .out_data(od[2]),
    .out_allow_in(out_allow_in), .stage_valid(sv[2]), .stall_cnt(cnt2));

  function automatic logic [7:0] cnt_of(int k);
    case (k)
      0:       return cnt0;
      1:       return cnt1;
      default: return {6'b0, cnt2};
    endcase
  endfunction

  function automatic int cmax(int k);
    return (k == 2) ? 3 : 255;
  endfunction

  function automatic logic m_allow(int k);
    if (k == 1) return msz[k] < 2;
    return (msz[k] == 0) || (ready_go && out_allow_in);
  endfunction

  task automatic chk(string nm, int k, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic apply(logic rst, logic fl, logic iv, logic [15:0] d, logic rg, logic oa);
    reset = rst; flush = fl; in_valid = iv; in_data = d; ready_go = rg; out_allow_in = oa;
    #3;
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        chk("in_allow_in", k, {15'b0, allow[k]}, {15'b0, m_allow(k)});
        chk("out_valid",   k, {15'b0, ov[k]},    {15'b0, msz[k] > 0 && rg});
        chk("stage_valid", k, {15'b0, sv[k]},    {15'b0, msz[k] > 0});
        chk("stall_cnt",   k, {8'b0, cnt_of(k)}, 16'(mcnt[k]));
        if (msz[k] > 0 && rg) chk("out_data", k, od[k], mbuf[k][0]);
      end
      if (ov[1] && oa) log1.push_back(od[1]);
    end
  endtask

  task automatic adv();
    logic al[3];
    logic of[3];
    for (int k = 0; k < 3; k++) begin
      al[k] = m_allow(k);
      of[k] = (msz[k] > 0) && ready_go && out_allow_in;
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        msz[k] = 0; mcnt[k] = 0;
      end else if (flush) begin
        msz[k] = 0;
      end else begin
        if (msz[k] > 0 && !of[k] && mcnt[k] < cmax(k)) mcnt[k]++;
        if (of[k]) begin
          mbuf[k][0] = mbuf[k][1];
          msz[k]--;
        end
        if (in_valid && al[k]) begin
          mbuf[k][msz[k]] = in_data;
          msz[k]++;
        end
      end
    end
    #1;
  endtask

  task automatic cyc(logic rst, logic fl, logic iv, logic [15:0] d, logic rg, logic oa);
    apply(rst, fl, iv, d, rg, oa);
    adv();
  endtask

  typedef struct packed {
    logic        iv;
    logic [15:0] d;
    logic        rg, oa;
    logic        e_allow, e_ov;
    logic [15:0] e_od;
    logic        e_sv;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t tbl[11];
  logic [15:0] exp3[3];

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; ready_go = 1'b0; out_allow_in = 1'b0;
    for (int k = 0; k < 3; k++) begin msz[k] = 0; mcnt[k] = 0; end
    @(posedge clk); #1;

    // no-skid stream 1,2,3 then 0xA5 held by ready_go=0 for three cycles (expectations for dut0)
    //            iv  d       rg oa   allow ov od      sv cnt
    tbl[0]  = '{1'b1, 16'h1,  1'b1, 1'b1, 1'b1, 1'b0, 16'h0,  1'b0, 8'd0};
    tbl[1]  = '{1'b1, 16'h2,  1'b1, 1'b1, 1'b1, 1'b1, 16'h1,  1'b1, 8'd0};
    tbl[2]  = '{1'b1, 16'h3,  1'b1, 1'b1, 1'b1, 1'b1, 16'h2,  1'b1, 8'd0};
    tbl[3]  = '{1'b0, 16'h0,  1'b1, 1'b1, 1'b1, 1'b1, 16'h3,  1'b1, 8'd0};
    tbl[4]  = '{1'b0, 16'h0,  1'b1, 1'b1, 1'b1, 1'b0, 16'h0,  1'b0, 8'd0};
    tbl[5]  = '{1'b1, 16'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0,  1'b0, 8'd0};
    tbl[6]  = '{1'b0, 16'h0,  1'b0, 1'b1, 1'b0, 1'b0, 16'h0,  1'b1, 8'd0};
    tbl[7]  = '{1'b0, 16'h0,  1'b0, 1'b1, 1'b0, 1'b0, 16'h0,  1'b1, 8'd1};
    tbl[8]  = '{1'b0, 16'h0,  1'b0, 1'b1, 1'b0, 1'b0, 16'h0,  1'b1, 8'd2};
    tbl[9]  = '{1'b0, 16'h0,  1'b1, 1'b1, 1'b1, 1'b1, 16'hA5, 1'b1, 8'd3};
    tbl[10] = '{1'b0, 16'h0,  1'b1, 1'b1, 1'b1, 1'b0, 16'h0,  1'b0, 8'd3};

    cyc(1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 11; i++) begin
      apply(0, 0, tbl[i].iv, tbl[i].d, tbl[i].rg, tbl[i].oa);
      chk("tbl_allow", 0, {15'b0, allow[0]}, {15'b0, tbl[i].e_allow});
      chk("tbl_ov",    0, {15'b0, ov[0]},    {15'b0, tbl[i].e_ov});
      chk("tbl_sv",    0, {15'b0, sv[0]},    {15'b0, tbl[i].e_sv});
      chk("tbl_cnt",   0, {8'b0, cnt0},      {8'b0, tbl[i].e_cnt});
      if (tbl[i].e_ov) chk("tbl_od", 0, od[0], tbl[i].e_od);
      adv();
    end

    // skid: 11 parks in the skid entry while downstream blocks, order preserved
    cyc(1, 0, 0, 0, 1, 1);
    log1.delete();
    cyc(0, 0, 1, 16'd10, 1, 1);
    cyc(0, 0, 1, 16'd11, 1, 0);
    apply(0, 0, 1, 16'd12, 1, 0);
    chk("skid_full_allow", 1, {15'b0, allow[1]}, 16'd0);
    chk("skid_head", 1, od[1], 16'd10);
    adv();
    cyc(0, 0, 1, 16'd12, 1, 1);
    cyc(0, 0, 1, 16'd12, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    exp3 = '{16'd10, 16'd11, 16'd12};
    chk("skid_count", 1, 16'(log1.size()), 16'd3);
    for (int i = 0; i < 3 && i < log1.size(); i++) chk("skid_order", 1, log1[i], exp3[i]);

    // flush with main and skid full and input offered
    log1.delete();
    cyc(0, 0, 1, 16'd20, 1, 0);
    cyc(0, 0, 1, 16'd21, 1, 0);
    apply(0, 1, 1, 16'd22, 1, 0);
    chk("pre_flush_sv", 1, {15'b0, sv[1]}, 16'd1);
    adv();
    apply(0, 0, 0, 0, 1, 1);
    chk("post_flush_sv", 1, {15'b0, sv[1]}, 16'd0);
    chk("post_flush_allow", 1, {15'b0, allow[1]}, 16'd1);
    adv();
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    chk("flushed_never_out", 1, 16'(log1.size()), 16'd0);
    // flushed input on an empty no-skid stage is dropped
    apply(0, 1, 1, 16'd23, 1, 1);
    adv();
    apply(0, 0, 0, 0, 1, 1);
    chk("flush_drop_in", 0, {15'b0, ov[0]}, 16'd0);
    adv();

    // 2-bit counter saturates, survives flush, cleared by reset
    cyc(1, 0, 0, 0, 1, 1);
    cyc(0, 0, 1, 16'd30, 1, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 1);
    apply(0, 1, 0, 0, 0, 1);
    chk("sat_cnt", 2, {14'b0, cnt2}, 16'd3);
    adv();
    apply(0, 0, 0, 0, 0, 1);
    chk("flush_keeps_cnt", 2, {14'b0, cnt2}, 16'd3);
    chk("flush_clears_sv", 2, {15'b0, sv[2]}, 16'd0);
    adv();
    cyc(1, 0, 0, 0, 0, 1);
    apply(0, 0, 0, 0, 0, 1);
    chk("reset_cnt", 2, {14'b0, cnt2}, 16'd0);
    adv();

    // reset mid-stream with every stage holding a payload
    cyc(0, 0, 1, 16'd40, 0, 1);
    cyc(0, 0, 1, 16'd41, 0, 1);
    cyc(1, 0, 1, 16'd42, 1, 1);
    apply(0, 0, 0, 0, 1, 1);
    for (int k = 0; k < 3; k++) begin
      chk("rst_ov", k, {15'b0, ov[k]}, 16'd0);
      chk("rst_allow", k, {15'b0, allow[k]}, 16'd1);
      chk("rst_cnt", k, {8'b0, cnt_of(k)}, 16'd0);
    end
    adv();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(255) == 0), ($urandom_range(15) == 0), $urandom_range(1) == 1,
          16'($urandom), ($urandom_range(3) != 0), ($urandom_range(3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
